// File: rtl/serial_addsub_word.sv
// serial_addsub_word: bit-serial add/subtract over a framed word, LSB digit first,
// with registered digit stream, assembled word and end-of-word carry/overflow flags.
module serial_addsub_word #(
  parameter int DIGIT_W    = 1,
  parameter int NUM_DIGITS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          sub,
  input  logic                          in_valid,
  input  logic [DIGIT_W-1:0]            x,
  input  logic [DIGIT_W-1:0]            y,
  output logic                          busy,
  output logic                          s_valid,
  output logic [DIGIT_W-1:0]            s,
  output logic [DIGIT_W*NUM_DIGITS-1:0] word_out,
  output logic                          done,
  output logic                          carry_out,
  output logic                          overflow
);
  localparam int W  = DIGIT_W * NUM_DIGITS;
  localparam int CW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state_q, state_d;
  logic               mode_q, mode_d, carry_q, carry_d;
  logic               s_valid_q, s_valid_d, done_q, done_d;
  logic               cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]      count_q, count_d;
  logic [DIGIT_W-1:0] s_q, s_d, ye;
  logic [W-1:0]       word_q, word_d;
  logic [DIGIT_W:0]   t;
  logic               take, last;
  always_comb begin
    ye        = y ^ {DIGIT_W{mode_q}};
    t         = {1'b0, x} + {1'b0, ye} + {{DIGIT_W{1'b0}}, carry_q};
    take      = state_q == RUN && in_valid;
    last      = take && count_q == CW'(NUM_DIGITS - 1);
    state_d   = state_q;
    mode_d    = mode_q;
    carry_d   = carry_q;
    count_d   = count_q;
    s_d       = s_q;
    word_d    = word_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    s_valid_d = take;
    done_d    = last;
    // subtraction is x + ~y + 1: the +1 is preloaded into the carry
    if (state_q == IDLE && start) begin
      state_d = RUN;
      mode_d  = sub;
      carry_d = sub;
      count_d = '0;
    end
    if (take) begin
      s_d     = t[DIGIT_W-1:0];
      carry_d = t[DIGIT_W];
      word_d  = {t[DIGIT_W-1:0], word_q[W-1:DIGIT_W]};
      count_d = count_q + 1'b1;
    end
    if (last) begin
      state_d = IDLE;
      cout_d  = t[DIGIT_W];
      ovf_d   = (x[DIGIT_W-1] == ye[DIGIT_W-1]) && (t[DIGIT_W-1] != x[DIGIT_W-1]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      s_q       <= '0;
      word_q    <= '0;
      s_valid_q <= 1'b0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      s_q       <= s_d;
      word_q    <= word_d;
      s_valid_q <= s_valid_d;
      done_q    <= done_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end
  assign busy      = state_q == RUN;
  assign s_valid   = s_valid_q;
  assign s         = s_q;
  assign word_out  = word_q;
  assign done      = done_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_addsub_word.sv
// tb_serial_addsub_word: directed and random words on an 8x1 and a 2x4 instance,
// checked against an arithmetic model of add/subtract with carry and signed overflow.
module tb_serial_addsub_word;
  logic       clk = 1'b0, reset = 1'b1;
  logic       start = 0, sub = 0, iv = 0, x = 0, y = 0;
  logic       busy, s_valid, s, done, carry_out, overflow;
  logic [7:0] word_out;
  logic       start4 = 0, sub4 = 0, iv4 = 0;
  logic [3:0] x4 = 0, y4 = 0, s4;
  logic       busy4, s_valid4, done4, carry_out4, overflow4;
  logic [7:0] word_out4;
  int         checks = 0, failures = 0;
  int         last_res;
  bit         last_c, last_ov;

  always #5 clk = ~clk;

  serial_addsub_word #(.DIGIT_W(1), .NUM_DIGITS(8)) u8 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .in_valid(iv), .x(x), .y(y),
    .busy(busy), .s_valid(s_valid), .s(s), .word_out(word_out), .done(done),
    .carry_out(carry_out), .overflow(overflow));

  serial_addsub_word #(.DIGIT_W(4), .NUM_DIGITS(2)) u4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .in_valid(iv4), .x(x4), .y(y4),
    .busy(busy4), .s_valid(s_valid4), .s(s4), .word_out(word_out4), .done(done4),
    .carry_out(carry_out4), .overflow(overflow4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int xv, input int yv, input bit sb,
                       output int res, output bit c, output bit ov);
    int sx, sy, r;
    res = sb ? (xv - yv) & 255 : (xv + yv) & 255;
    c   = sb ? (xv >= yv) : (xv + yv > 255);
    sx  = xv >= 128 ? xv - 256 : xv;
    sy  = yv >= 128 ? yv - 256 : yv;
    r   = sb ? sx - sy : sx + sy;
    ov  = r < -128 || r > 127;
  endtask

  task automatic word8(input logic [7:0] xv, input logic [7:0] yv, input bit sb,
                       input int nstall, input bit poke);
    int res;
    bit c, ov;
    int st[8];
    model(xv, yv, sb, res, c, ov);
    foreach (st[i]) st[i] = 0;
    repeat (nstall) st[$urandom_range(1, 7)]++;
    start = 1; sub = sb; iv = 0;
    @(negedge clk);
    start = 0; sub = !sb;
    chk("busy_after_start", busy, 1);
    chk("done_single_pulse", done, 0);
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < st[d]; k++) begin
        iv = 0; x = 1'($urandom); y = 1'($urandom); start = poke;
        @(negedge clk);
        chk("stall_s_valid", s_valid, 0);
        chk("stall_done", done, 0);
        chk("stall_busy", busy, 1);
      end
      iv = 1; x = xv[d]; y = yv[d]; start = poke && d == 3;
      @(negedge clk);
      chk("digit_s_valid", s_valid, 1);
      chk("digit_s", s, res[d]);
      if (d < 7) begin
        chk("early_done", done, 0);
        chk("run_busy", busy, 1);
      end
    end
    iv = 0; start = 0;
    chk("done", done, 1);
    chk("busy_fall", busy, 0);
    chk("word_out", word_out, res);
    chk("carry_out", carry_out, c);
    chk("overflow", overflow, ov);
    last_res = res; last_c = c; last_ov = ov;
  endtask

  task automatic word4(input logic [7:0] xv, input logic [7:0] yv, input bit sb);
    int res;
    bit c, ov;
    logic [7:0] r8;
    model(xv, yv, sb, res, c, ov);
    r8 = res[7:0];
    start4 = 1; sub4 = sb; iv4 = 0;
    @(negedge clk);
    start4 = 0;
    chk("w4_busy", busy4, 1);
    for (int d = 0; d < 2; d++) begin
      iv4 = 1; x4 = xv[4*d +: 4]; y4 = yv[4*d +: 4];
      @(negedge clk);
      chk("w4_s_valid", s_valid4, 1);
      chk("w4_s", s4, r8[4*d +: 4]);
      chk("w4_done", done4, d == 1);
    end
    iv4 = 0;
    chk("w4_word_out", word_out4, res);
    chk("w4_carry_out", carry_out4, c);
    chk("w4_overflow", overflow4, ov);
    chk("w4_busy_fall", busy4, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_word_out", word_out, 0);
    chk("rst_done", done, 0);
    chk("rst_carry_out", carry_out, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst4_word_out", word_out4, 0);
    chk("rst4_busy", busy4, 0);
    reset = 0;
    @(negedge clk);
    word8(8'h3C, 8'h0F, 0, 0, 0);
    chk("add_3c_0f", word_out, 8'h4B);
    for (int k = 0; k < 3; k++) begin
      iv = 1; x = 1'($urandom); y = 1'($urandom);
      @(negedge clk);
      chk("idle_s_valid", s_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_hold_word", word_out, last_res);
      chk("idle_hold_carry", carry_out, last_c);
      chk("idle_hold_ovf", overflow, last_ov);
    end
    iv = 0;
    word8(8'hFF, 8'h01, 0, 0, 0);
    @(negedge clk);
    word8(8'h70, 8'h20, 0, 0, 0);
    chk("add_ovf_flag", overflow, 1);
    @(negedge clk);
    word8(8'h05, 8'h07, 1, 0, 0);
    chk("sub_borrow", carry_out, 0);
    @(negedge clk);
    word8(8'h80, 8'h01, 1, 0, 0);
    chk("sub_ovf_word", word_out, 8'h7F);
    @(negedge clk);
    word8(8'h3C, 8'h0F, 0, 3, 0);
    @(negedge clk);
    word8(8'h3C, 8'h0F, 0, 0, 1);
    @(negedge clk);
    word8(8'($urandom), 8'($urandom), 1'($urandom), 0, 0);
    word8(8'h01, 8'h01, 0, 0, 0);
    chk("b2b_word", word_out, 8'h02);
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      word8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end
    @(negedge clk);
    start = 1; sub = 0;
    @(negedge clk);
    start = 0;
    for (int d = 0; d < 4; d++) begin
      iv = 1; x = 1'($urandom); y = 1'($urandom);
      @(negedge clk);
    end
    reset = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_s_valid", s_valid, 0);
    chk("abort_s", s, 0);
    chk("abort_word_out", word_out, 0);
    chk("abort_carry", carry_out, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_done", done, 0);
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      iv = 1; x = 1'($urandom); y = 1'($urandom);
      @(negedge clk);
      chk("post_abort_done", done, 0);
      chk("post_abort_busy", busy, 0);
      chk("post_abort_word", word_out, 0);
    end
    iv = 0;
    word8(8'h3C, 8'h0F, 0, 0, 0);
    @(negedge clk);
    word4(8'h9C, 8'h78, 0);
    chk("w4_9c_78", word_out4, 8'h14);
    for (int n = 0; n < 10; n++) word4(8'($urandom), 8'($urandom), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
